// File: rtl/serial_byte_tx.sv
// serial_byte_tx: async-serial byte transmitter (start, DATA_BITS data LSB first, one stop bit).
module serial_byte_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] TxData,
  input  logic       TxLoad,
  output logic       TxReady,
  output logic       TxOut,
  output logic       TxDone
);
  localparam int TW = CLKS_PER_BIT > 2 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic out_q, out_d, ready_q, ready_d, done_q, done_d;
  logic period_end, last_bit, unused_data;
  assign period_end = tick_q == TW'(CLKS_PER_BIT - 1);
  assign last_bit = bit_q == 3'(DATA_BITS - 1);
  assign unused_data = ^TxData;
  assign TxOut = out_q;
  assign TxReady = ready_q;
  assign TxDone = done_q;
  always_comb begin
    state_d = state_q;
    tick_d = (state_q == IDLE || period_end) ? '0 : tick_q + TW'(1);
    bit_d = bit_q;
    sh_d = sh_q;
    out_d = out_q;
    ready_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = TxLoad ? START : IDLE;
        sh_d = TxLoad ? TxData[DATA_BITS-1:0] : sh_q;
        bit_d = '0;
        out_d = !TxLoad;
        ready_d = !TxLoad;
      end
      START: begin
        state_d = period_end ? DATA : START;
        bit_d = '0;
        out_d = period_end ? sh_q[0] : 1'b0;
      end
      DATA: begin
        sh_d = period_end ? sh_q >> 1 : sh_q;
        bit_d = !period_end ? bit_q : last_bit ? 3'd0 : bit_q + 3'd1;
        state_d = (period_end && last_bit) ? STOP : DATA;
        out_d = state_d == STOP ? 1'b1 : sh_d[0];
      end
      STOP: begin
        // A load held at frame end chains straight into the next start bit.
        state_d = !period_end ? STOP : TxLoad ? START : IDLE;
        sh_d = (period_end && TxLoad) ? TxData[DATA_BITS-1:0] : sh_q;
        out_d = !(period_end && TxLoad);
        ready_d = period_end;
        done_d = period_end;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      out_q <= 1'b1;
      ready_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      out_q <= out_d;
      ready_q <= ready_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_serial_byte_tx.sv
// tb_serial_byte_tx: scoreboard bench; unit 0 is C=4/8 bits, unit 1 is C=2/5 bits.
module tb_serial_byte_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rs = 1'b1;
  logic [1:0] ld = 2'b11;
  logic [1:0][7:0] din = '0;
  logic [1:0] tx_out, tx_rdy, tx_dn;
  logic [7:0] q0[$], q1[$];
  logic [7:0] cur [2];
  int k [2];
  bit [1:0] act = '0, pend = '0;
  int cyc = 0, checks = 0, errors = 0;

  serial_byte_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) u0 (
    .clk(clk), .reset(reset), .TxData(din[0]), .TxLoad(ld[0]),
    .TxReady(tx_rdy[0]), .TxOut(tx_out[0]), .TxDone(tx_dn[0]));
  serial_byte_tx #(.CLKS_PER_BIT(2), .DATA_BITS(5)) u1 (
    .clk(clk), .reset(reset), .TxData(din[1]), .TxLoad(ld[1]),
    .TxReady(tx_rdy[1]), .TxOut(tx_out[1]), .TxDone(tx_dn[1]));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    rs <= reset;
    cyc <= cyc + 1;
  end

  task automatic chk(input int u, input logic a, input logic b, input string n);
    checks++;
    if (a !== b) begin
      errors++;
      $display("FAIL %s unit%0d cycle %0d got %b want %b", n, u, cyc, a, b);
    end
  endtask

  // Frame receiver: aligns on the start bit and checks every cycle of the frame.
  task automatic mon(input int u);
    int c, db, len, p;
    logic e, st;
    c = u ? 2 : 4;
    db = u ? 5 : 8;
    len = c * (db + 2);
    st = 1'b0;
    if (rs) begin
      act[u] = 1'b0;
      pend[u] = 1'b0;
    end
    if (pend[u]) begin
      chk(u, tx_dn[u], 1'b1, "done_pulse");
      chk(u, tx_rdy[u], 1'b1, "done_ready");
      pend[u] = 1'b0;
      act[u] = 1'b0;
      st = 1'b1;
    end else chk(u, tx_dn[u], 1'b0, "done_low");
    if (!act[u]) begin
      if (tx_out[u] === 1'b0) begin
        if ((u ? q1.size() : q0.size()) == 0) begin
          errors++;
          $display("FAIL spurious_frame unit%0d cycle %0d got start bit want idle", u, cyc);
        end else begin
          cur[u] = u ? q1.pop_front() : q0.pop_front();
          act[u] = 1'b1;
          k[u] = 0;
          chk(u, tx_rdy[u], st, "ready_at_start");
        end
      end else if (!st) begin
        chk(u, tx_out[u], 1'b1, "idle_out");
        chk(u, tx_rdy[u], 1'b1, "idle_ready");
      end
    end
    if (act[u]) begin
      p = k[u] / c;
      e = p == 0 ? 1'b0 : p <= db ? cur[u][p-1] : 1'b1;
      chk(u, tx_out[u], e, "txout_bit");
      if (k[u] > 0) chk(u, tx_rdy[u], 1'b0, "busy_ready");
      if (k[u] == len - 1) pend[u] = 1'b1;
      k[u]++;
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int u, input logic [7:0] d);
    if (u == 0) q0.push_back(d);
    else q1.push_back(d);
    din[u] = d;
    ld[u] = 1'b1;
    tick(1);
    ld[u] = 1'b0;
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    ld = 2'b00;
    tick(3);
    load(0, 8'hA5);
    tick(9);
    din[0] = 8'hFF;
    ld[0] = 1'b1;
    tick(1);
    ld[0] = 1'b0;
    din[0] = 8'h00;
    tick(45);
    q0.push_back(8'h00);
    q0.push_back(8'hFF);
    din[0] = 8'h00;
    ld[0] = 1'b1;
    tick(21);
    din[0] = 8'hFF;
    tick(20);
    ld[0] = 1'b0;
    tick(45);
    load(0, 8'h3C);
    tick(17);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(5);
    load(0, 8'hC3);
    tick(45);
    load(1, 8'h3F);
    tick(20);
    load(1, 8'hEA);
    tick(20);
    chk(0, q0.size() == 0 && !act[0] && !pend[0], 1'b1, "all_frames_sent");
    chk(1, q1.size() == 0 && !act[1] && !pend[1], 1'b1, "all_frames_sent");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_byte_tx.md
Name: serial_byte_tx

Overview:
- Asynchronous-serial byte transmitter; the transmit-side counterpart of the bit-counting serial receiver in the micro's I/O path.
- Accepts a parallel byte over a load/ready handshake and drives a framed stream on one line: start bit, DATA_BITS data bits LSB first, one stop bit.
- Bit timing comes from an internal clock divider.
- Internally: a bit counter (clear/increment style), a baud tick counter and a frame FSM.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- TxData  input  8  byte to send; only bits [DATA_BITS-1:0] are used.
- TxLoad  input  1  load request; accepted only on a cycle where TxReady=1.
- TxReady  output  1  high when idle and able to accept a load.
- TxOut  output  1  serial line; idles high.
- TxDone  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (sampled at posedge): TxOut=1, TxReady=1, TxDone=0, state=IDLE, all counters=0, shift register=0. Reset wins over everything and aborts any frame in progress; TxOut is 1 after that edge.
- States: IDLE, START, DATA, STOP. Notation: C=CLKS_PER_BIT, N = the edge at which a load is accepted.
- IDLE:
  - TxOut=1, TxReady=1.
  - If TxLoad=1 at edge N: latch TxData into the shift register, clear the tick and bit counters, go to START.
  - After edge N: TxOut=0, TxReady=0.
- Tick counter:
  - Counts 0..C-1 in every non-IDLE state.
  - A bit period ends when tick=C-1; the counter wraps to 0 on that edge.
  - Width is ceil(log2(C)) bits, minimum 1.
- START: TxOut=0 for exactly C cycles; then go to DATA with bit counter=0.
- DATA:
  - TxOut = shift register bit 0.
  - At each bit-period end: shift right by one and increment the bit counter.
  - After DATA_BITS periods (bit counter = DATA_BITS-1 at period end): clear the bit counter and go to STOP.
  - Data bit i is driven from edge N+C*(1+i) to edge N+C*(2+i).
- STOP: TxOut=1 for exactly C cycles.
- Frame completion (edge N+C*(DATA_BITS+2)):
  - Go to IDLE; TxReady=1; TxDone=1 for exactly that one cycle.
  - Total frame length is C*(DATA_BITS+2) cycles.
- TxDone: 0 at all other times.
- TxLoad:
  - Ignored while TxReady=0; no queuing, and TxData changes mid-frame have no effect.
  - TxLoad held continuously starts a new frame on the TxDone cycle. Back-to-back frames therefore have no idle gap: stop bit is followed directly by the next start bit, and a 1-cycle TxReady window coincides with TxDone.
- Outputs are registered: no combinational path from inputs to TxOut, TxReady or TxDone.
- Latency: TxLoad accepted at edge N → start bit visible after edge N (1 cycle).

Test Plan:
- Reset: hold reset for 3 cycles with TxLoad=1 → TxOut=1, TxReady=1, TxDone=0 throughout; no frame starts while reset is high.
- Single frame, C=4, DATA_BITS=8: pulse TxLoad with TxData=0xA5 → TxOut per 4-cycle period is 0, 1,0,1,0,0,1,0,1, 1; TxReady low for 40 cycles; TxDone high exactly at cycle 40 after the load edge.
- Busy rejection: during the 0xA5 frame, pulse TxLoad with TxData=0xFF at cycle 10 → frame bits unchanged; no second frame follows.
- Back-to-back: hold TxLoad=1 with 0x00 then 0xFF → the stop bit of frame 1 is followed immediately by the start bit of frame 2; TxDone pulses at cycles 40 and 80; TxOut is high for only the 4 stop-bit cycles between frames.
- Reset mid-frame: assert reset during data bit 3 → TxOut=1 and TxReady=1 after the next edge; no TxDone; a fresh load afterwards produces a complete, correct frame.
- Parameter corner: C=2, DATA_BITS=5, TxData=0x3F → frame is 14 cycles; bits 0,1,1,1,1,1,1; upper TxData bits ignored.
